// File: rtl/xgmii_dly_ctrl.sv
// xgmii_dly_ctrl: write/read sequencer that turns a dual-port RAM into a fixed-latency XGMII delay line.
// Optional fill statistics counter is built when XGMII_DLY_FILL_CNT_EN is defined.
module xgmii_dly_ctrl #(
    parameter int            DEPTH     = 2560,
    parameter int            AW        = 12,
    parameter int            DW        = 38,
    parameter int            MIN_DLY   = 3,
    parameter logic [DW-1:0] IDLE_WORD = 38'h0F_07070707
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_en,
    input  logic [AW-1:0] cfg_delay,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          dout_fill,
    output logic [AW-1:0] dly_act,
    output logic          busy,
    output logic          ram_ena,
    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dina,
    output logic          ram_rstb,
    output logic [AW-1:0] ram_addrb,
    input  logic [DW-1:0] ram_doutb,
    input  logic          cnt_clr,
    output logic [15:0]   fill_cnt
);
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

    localparam logic [AW-1:0] DMIN = AW'(MIN_DLY);
    localparam logic [AW-1:0] DMAX = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] wp_q, wp_d, fcnt_q, fcnt_d, dly_q, dly_d;
    logic [AW-1:0] d_clamp, wp_inc, rd_ofs, rp;
    logic [DW-1:0] dout_q;
    logic          fill_q;

    always_comb begin
        if (cfg_delay < DMIN)      d_clamp = DMIN;
        else if (cfg_delay > DMAX) d_clamp = DMAX;
        else                       d_clamp = cfg_delay;
    end

    assign wp_inc = (wp_q == DMAX) ? '0 : wp_q + AW'(1);
    // Read trails write by D-2: one cycle for RAM latency, one for the dout register.
    // rd_ofs lies in [1, DEPTH-3], so rp never equals wp; modular AW-bit math is exact here.
    assign rd_ofs = dly_q - AW'(2);
    assign rp     = (wp_q >= rd_ofs) ? wp_q - rd_ofs : wp_q + AW'(DEPTH) - rd_ofs;

    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        fcnt_d  = fcnt_q;
        dly_d   = dly_q;
        case (state_q)
            S_IDLE: begin
                wp_d   = '0;
                fcnt_d = '0;
                if (cfg_en) begin
                    state_d = S_FILL;
                    dly_d   = d_clamp;
                end
            end
            S_FILL: begin
                wp_d   = wp_inc;
                fcnt_d = fcnt_q + AW'(1);
                if (fcnt_q == dly_q - AW'(1)) state_d = S_RUN;
            end
            S_RUN:   wp_d = wp_inc;
            default: state_d = S_IDLE;
        endcase
        // Disable has priority over a delay change; a change restarts the fill without a wp gap.
        if (state_q != S_IDLE) begin
            if (!cfg_en) begin
                state_d = S_IDLE;
                wp_d    = '0;
                fcnt_d  = '0;
            end else if (d_clamp != dly_q) begin
                state_d = S_FILL;
                dly_d   = d_clamp;
                fcnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wp_q    <= '0;
            fcnt_q  <= '0;
            dly_q   <= DMIN;
            dout_q  <= IDLE_WORD;
            fill_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            fcnt_q  <= fcnt_d;
            dly_q   <= dly_d;
            dout_q  <= (state_d == S_RUN) ? ram_doutb : IDLE_WORD;
            fill_q  <= (state_d != S_RUN);
        end
    end

    assign dout      = dout_q;
    assign dout_fill = fill_q;
    assign dly_act   = dly_q;
    assign busy      = (state_q == S_FILL);
    assign ram_ena   = (state_q != S_IDLE);
    assign ram_wea   = (state_q != S_IDLE);
    assign ram_rstb  = (state_q == S_IDLE);
    assign ram_addra = wp_q;
    assign ram_addrb = (state_q == S_IDLE) ? '0 : rp;
    assign ram_dina  = din;

`ifdef XGMII_DLY_FILL_CNT_EN
    logic [15:0] fc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                             fc_q <= '0;
        else if (cnt_clr)                                       fc_q <= '0;
        else if (fill_q && state_q != S_IDLE && fc_q != 16'hFFFF) fc_q <= fc_q + 16'd1;
    end
    assign fill_cnt = fc_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign fill_cnt       = '0;
`endif

endmodule

// File: tb/tb_xgmii_dly_ctrl.sv
// tb_xgmii_dly_ctrl: directed bench with a behavioural 2560x38 RAM, clamp/latency vector table
// and hand-written sequences for delay change, disable and async reset.
module tb_xgmii_dly_ctrl;
    localparam logic [37:0] IDLE = 38'h0F_07070707;

    logic        clk = 1'b0;
    logic        rst_n, cfg_en, cnt_clr;
    logic [11:0] cfg_delay;
    logic [37:0] din, dout, ram_dina, ram_doutb;
    logic        dout_fill, busy, ram_ena, ram_wea, ram_rstb;
    logic [11:0] dly_act, ram_addra, ram_addrb;
    logic [15:0] fill_cnt;

    xgmii_dly_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_delay(cfg_delay), .din(din),
        .dout(dout), .dout_fill(dout_fill), .dly_act(dly_act), .busy(busy),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_rstb(ram_rstb), .ram_addrb(ram_addrb), .ram_doutb(ram_doutb),
        .cnt_clr(cnt_clr), .fill_cnt(fill_cnt)
    );

    always #5 clk = ~clk;

    logic [37:0] mem [0:2559];
    always @(posedge clk) begin
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
        if (ram_rstb) ram_doutb <= '0;
        else          ram_doutb <= mem[ram_addrb];
    end

    int          n_cmp = 0, n_bad = 0, cyc = 0;
    logic [37:0] hist [0:8191];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        hist[cyc & 8191] = din;
        @(posedge clk);
        #1;
        cyc++;
        din = din + 38'd1;
    endtask

    // Called on the first FILL cycle (T0); runs through fill plus nrun data cycles.
    task automatic measure(input string nm, input int d, input int nrun, input bit exp_wrap);
        int t0 = cyc;
        int n = 0;
        bit ok_idle = 1, ok_lat = 1, ok_coll = 1, ok_cont = 1, wrap = 0;
        logic [11:0] pa;
        chk({nm, " dly_act"}, dly_act, d);
        chk({nm, " busy@T0"}, busy, 1);
        pa = ram_addra;
        while (busy && n < 3000) begin
            if (!dout_fill || dout !== IDLE) ok_idle = 0;
            if (ram_addra == ram_addrb) ok_coll = 0;
            tick(); n++;
            if (ram_addra != ((pa == 12'd2559) ? 12'd0 : pa + 12'd1)) ok_cont = 0;
            if (pa == 12'd2559 && ram_addra == 12'd0) wrap = 1;
            pa = ram_addra;
        end
        chk({nm, " fill cycles"}, n, d);
        chk({nm, " fill idle"}, ok_idle, 1);
        chk({nm, " first word"}, dout, hist[t0 & 8191]);
        for (int i = 0; i < nrun; i++) begin
            if (dout_fill || dout !== hist[(cyc - d) & 8191]) ok_lat = 0;
            if (ram_addra == ram_addrb) ok_coll = 0;
            tick();
            if (ram_addra != ((pa == 12'd2559) ? 12'd0 : pa + 12'd1)) ok_cont = 0;
            if (pa == 12'd2559 && ram_addra == 12'd0) wrap = 1;
            pa = ram_addra;
        end
        chk({nm, " latency"}, ok_lat, 1);
        chk({nm, " no collision"}, ok_coll, 1);
        chk({nm, " wp continuous"}, ok_cont, 1);
        chk({nm, " wp wrap"}, wrap, exp_wrap);
    endtask

    task automatic disable_chk(input string nm);
        cfg_en = 1'b0;
        tick();
        chk({nm, " off busy"}, busy, 0);
        chk({nm, " off wp"}, ram_addra, 0);
        chk({nm, " off dout"}, dout, IDLE);
    endtask

    typedef struct { int cfg; int d; int nrun; bit wrap; } vec_t;
    vec_t tbl [8];

    initial begin
        tbl[0] = '{10, 10, 20, 0};
        tbl[1] = '{0, 3, 20, 0};
        tbl[2] = '{2, 3, 10, 0};
        tbl[3] = '{3, 3, 10, 0};
        tbl[4] = '{4, 4, 10, 0};
        tbl[5] = '{4000, 2559, 6000, 1};
        tbl[6] = '{2560, 2559, 5, 1};
        tbl[7] = '{100, 100, 30, 0};

        rst_n = 1'b1; cfg_en = 1'b0; cnt_clr = 1'b0; cfg_delay = '0; din = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst dout", dout, IDLE);
        chk("rst dout_fill", dout_fill, 1);
        chk("rst dly_act", dly_act, 3);
        chk("rst busy", busy, 0);
        chk("rst ram_ena", ram_ena, 0);
        chk("rst ram_wea", ram_wea, 0);
        chk("rst ram_rstb", ram_rstb, 1);
        chk("rst wp", ram_addra, 0);
        chk("rst fill_cnt", fill_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(); tick();

        for (int i = 0; i < 8; i++) begin
            cfg_delay = 12'(tbl[i].cfg);
            cfg_en    = 1'b1;
            tick();
            measure($sformatf("vec%0d", i), tbl[i].d, tbl[i].nrun, tbl[i].wrap);
            disable_chk($sformatf("vec%0d", i));
        end

        // Delay change 100 -> 20 while in RUN
        cfg_delay = 12'd100; cfg_en = 1'b1;
        tick();
        measure("pre-chg", 100, 10, 0);
        begin
            logic [11:0] pa;
            pa = ram_addra;
            cfg_delay = 12'd20;
            tick();
            chk("chg wp step", ram_addra, pa + 12'd1);
        end
        measure("chg", 20, 30, 0);

        // Disable and delay change together: disable wins
        cfg_delay = 12'd33;
        disable_chk("dis+chg");

        // Drop enable mid-FILL
        cfg_delay = 12'd50; cfg_en = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("midfill busy", busy, 1);
        cfg_delay = 12'd7;
        disable_chk("midfill");
        chk("midfill wea", ram_wea, 0);
        chk("midfill fill", dout_fill, 1);

        // Fill statistics
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        chk("fc cleared", fill_cnt, 0);
        cfg_delay = 12'd50; cfg_en = 1'b1;
        tick();
        measure("fc", 50, 5, 0);
`ifdef XGMII_DLY_FILL_CNT_EN
        chk("fc after fill", fill_cnt, 50);
`else
        chk("fc after fill", fill_cnt, 0);
`endif
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        chk("fc clr pulse", fill_cnt, 0);

        // Async reset in RUN: outputs return immediately, no writes while held
        #2 rst_n = 1'b0;
        #1;
        chk("arst dout", dout, IDLE);
        chk("arst fill", dout_fill, 1);
        chk("arst dly_act", dly_act, 3);
        chk("arst busy", busy, 0);
        chk("arst wea", ram_wea, 0);
        chk("arst rstb", ram_rstb, 1);
        chk("arst wp", ram_addra, 0);
        @(posedge clk); #1;
        chk("arst hold wea", ram_wea, 0);
        chk("arst hold ena", ram_ena, 0);
        cfg_en = 1'b0;
        rst_n  = 1'b1;
        tick();
        chk("post-rst busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/xgmii_dly_ctrl.md
Name: xgmii_dly_ctrl

Overview:
- Sequencer for the 2560x38 dual-port delay RAM in the 10G PLA path; turns it into a programmable fixed-latency XGMII delay line.
- Takes one 38-bit word per clock and writes it at a wrapping write pointer.
- Issues reads at a trailing pointer and registers the RAM output.
- Inserts IDLE_WORD while the line fills after enable or a delay change.

Parameters:
- DEPTH, 2560, RAM words; pointer wrap point.
- AW, 12, RAM address width.
- DW, 38, word width.
- MIN_DLY, 3, minimum legal delay in cycles: 1 read-issue, 1 RAM read latency, 1 output register.
- IDLE_WORD, 38'h0F_07070707, fill pattern: XGMII idle, ctrl nibble F, upper bits 0.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- cfg_en  in  1  delay line enable
- cfg_delay  in  12  requested din-to-dout delay in cycles
- din  in  38  input word, one per clock
- dout  out  38  delayed word, registered
- dout_fill  out  1  dout is inserted IDLE_WORD
- dly_act  out  12  delay currently applied, after clamping
- busy  out  1  state is FILL
- ram_ena  out  1  RAM port-A enable
- ram_wea  out  1  RAM write enable
- ram_addra  out  12  write address
- ram_dina  out  38  write data (equals din)
- ram_rstb  out  1  RAM port-B output reset, active high
- ram_addrb  out  12  read address
- ram_doutb  in  38  RAM read data, 1-cycle latency
- cnt_clr  in  1  clears fill_cnt
- fill_cnt  out  16  fill statistics (see Optional Feature)

Behaviour:
- Reset values: dout=IDLE_WORD, dout_fill=1, dly_act=MIN_DLY, busy=0, wp=0, all RAM controls 0 except ram_rstb=1, fill_cnt=0.
- Clamp rule: D = MIN_DLY if cfg_delay<MIN_DLY; D = DEPTH-1 if cfg_delay>DEPTH-1; otherwise D = cfg_delay.
- Pointers:
  - wp runs 0..DEPTH-1 and wraps to 0.
  - rp = wp-(D-2), plus DEPTH if the difference is negative. Combinational from the registered wp.
  - ram_addra=wp, ram_addrb=rp.
  - rp never equals wp, so there is no same-address read/write collision.
- States:
  - IDLE:
    - ram_ena=ram_wea=0, ram_rstb=1, wp held at 0.
    - dout=IDLE_WORD, dout_fill=1.
    - cfg_en=1 latches D into dly_act and moves to FILL.
  - FILL:
    - ram_ena=ram_wea=1, ram_rstb=0; wp increments every cycle.
    - fcnt counts cycles from entry (T0 = first FILL cycle, first write).
    - dout_fill=1 and dout=IDLE_WORD through cycle T0+D-1.
    - When fcnt reaches D-1, move to RUN.
  - RUN:
    - dout = registered ram_doutb; dout_fill=0.
    - At T0+D, dout = din captured at T0. Steady-state latency is exactly dly_act cycles.
- Delay change: in FILL or RUN, if the clamped cfg_delay differs from dly_act:
  - latch the new D and re-enter FILL with fcnt=0 (T0 = next cycle);
  - keep wp running without a gap.
  - Data in flight under the old delay is discarded.
- cfg_en=0 in any state: next cycle IDLE, wp=0, dout=IDLE_WORD. The change is not smoothed.
- Simultaneous cfg_en fall and delay change: disable wins.
- busy=1 exactly while the state is FILL.
- Async reset mid-operation returns everything to reset values immediately; no RAM write occurs while rst_n=0.

Optional Feature:
- Macro XGMII_DLY_FILL_CNT_EN.
- Defined:
  - fill_cnt increments on every cycle with dout_fill=1 while state is not IDLE.
  - 16-bit saturating at 16'hFFFF.
  - cnt_clr synchronously clears it to 0; clear wins over increment in the same cycle.
- Undefined: fill_cnt is tied to 0, cnt_clr is ignored, and no counter logic is inferred.

Test Plan:
- Reset, cfg_en=1, cfg_delay=10, din = incrementing counter → dout_fill=1 for 10 cycles; then dout = din delayed exactly 10 cycles; dly_act=10; busy high 10 cycles.
- cfg_delay=0 and then 4000 → dly_act=3 and 2559 respectively; measured latency matches; no read/write address collision.
- Run 6000 cycles at delay 2559 → ram_addra wraps 2559→0; output sequence continuous with no duplicates or gaps.
- In RUN at delay 100, change cfg_delay to 20 → 20 fill cycles of IDLE_WORD, then din delayed 20; ram_addra has no discontinuity.
- Drop cfg_en mid-FILL, then assert rst_n=0 mid-RUN → IDLE next cycle with wp=0; reset values immediate, ram_wea=0.
- With XGMII_DLY_FILL_CNT_EN, enable at delay 50 → fill_cnt=50. Pulse cnt_clr → 0. Without the macro → fill_cnt stays 0.
